// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode codes, FSM encoding and helpers shared by the LED arbiter.
package led_seq_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        SOLID = 2'b01,
        BLINK = 2'b10,
        FLASH = 2'b11
    } mode_t;

    // Encoding doubles as the one-hot grant value.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic logic [1:0] led_map(input mode_t m, input logic p);
        return m == SOLID ? 2'b11 :
               m == BLINK ? {~p, p} :
               m == FLASH ? {p, p} : 2'b00;
    endfunction

endpackage

// File: rtl/led_seq_arb_tick_gen.sv
// tick_gen: blink prescaler, one-cycle tick every TICK_DIV enabled cycles.
module tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int TW = cnt_w(TICK_DIV);

    logic [TW-1:0] cnt;

    assign tick = en && cnt == TW'(TICK_DIV - 1);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/led_seq_arb.sv
// led_seq_arb: round-robin arbiter sharing one LED pair between two requesters,
// each driving it in its own display mode for slots of TICK_DIV*SLOT_TICKS cycles.
module led_seq_arb
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int SLOT_TICKS = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [1:0] REQ,
    input  logic [1:0] MODE0,
    input  logic [1:0] MODE1,
    output logic [1:0] GNT,
    output logic [1:0] LED,
    output logic       BUSY
);

    localparam int SW = cnt_w(SLOT_TICKS);

    state_t        st, st_nx, other;
    logic          last, phase, phase_nx, tick, entry;
    logic          holder, hreq, oreq, end_slot;
    logic [SW-1:0] slot;
    logic [1:0]    mode_nx, led_nx;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .clr      (entry),
        .en       (st != IDLE),
        .tick     (tick)
    );

    // entry marks every grant start, including a same-holder slot restart.
    always_comb begin
        st_nx    = st;
        entry    = 1'b0;
        holder   = st == GRANT1;
        hreq     = REQ[holder];
        oreq     = REQ[~holder];
        other    = holder ? GRANT0 : GRANT1;
        end_slot = tick && slot == SW'(SLOT_TICKS - 1);
        if (st == IDLE) begin
            entry = |REQ;
            st_nx = REQ[0] && (!REQ[1] || last) ? GRANT0 : REQ[1] ? GRANT1 : IDLE;
        end else if (!hreq) begin
            entry = oreq;
            st_nx = oreq ? other : IDLE;
        end else if (end_slot) begin
            entry = 1'b1;
            st_nx = oreq ? other : st;
        end
        phase_nx = entry ? 1'b0 : tick ? ~phase : phase;
        mode_nx  = st_nx == GRANT1 ? MODE1 : MODE0;
        led_nx   = st_nx == IDLE ? 2'b00 : led_map(mode_t'(mode_nx), phase_nx);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st    <= IDLE;
            last  <= 1'b1;
            phase <= 1'b0;
            slot  <= '0;
            GNT   <= 2'b00;
            LED   <= 2'b00;
        end else begin
            st    <= st_nx;
            phase <= phase_nx;
            slot  <= entry ? '0 : tick ? slot + 1'b1 : slot;
            GNT   <= st_nx;
            LED   <= led_nx;
            if (entry)
                last <= st_nx == GRANT1;
        end
    end

    assign BUSY = |GNT;

endmodule

// File: doc/led_seq_arb.md
LED_SEQ_ARB -- requirements
Module: led_seq_arb

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clock cycles per blink tick, minimum 1 (1 s at 50 MHz).
REQ-002 SHALL have parameter SLOT_TICKS, default 4: ticks per grant slot, minimum 1.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, rising-edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ  in  2  REQ[i] high = requester i wants the LED pair.
REQ-006 SHALL have ports MODE0 and MODE1  in  2 each  display mode of requester 0 and requester 1.
REQ-007 SHALL have port GNT  out  2  one-hot grant, or 00 when idle.
REQ-008 SHALL have port LED  out  2  board LED pair.
REQ-009 SHALL have port BUSY  out  1  high when GNT != 00.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT0 and GRANT1; GNT SHALL be 00, 01 or 10 respectively.
REQ-011 In IDLE, SHALL enter GRANTi on the next edge when only REQ[i] is high.
REQ-012 In IDLE with both requests high, SHALL grant the requester not served last; the last-served pointer resets to 1, so requester 0 wins first after reset.
REQ-013 SHALL run the tick counter 0..TICK_DIV-1 and pulse tick for one cycle at TICK_DIV-1, wrapping to 0.
REQ-014 SHALL clear the tick counter, phase and slot counter on every grant entry, including a slot restart, so each slot's first phase is a full TICK_DIV cycles.
REQ-015 While granted, phase SHALL toggle on each tick and the slot counter SHALL increment on each tick.
REQ-016 At a tick with slot counter = SLOT_TICKS-1 (end of slot, TICK_DIV*SLOT_TICKS cycles), SHALL move to the other requester if its REQ is high; else restart the same slot if the holder's REQ is still high; else go to IDLE.
REQ-017 If the holder drops REQ mid-slot, SHALL leave on the next edge without waiting for a tick: to the other requester if it is requesting, else to IDLE.
REQ-018 If a holder-drop and an end-of-slot occur in the same cycle, SHALL apply REQ-017.
REQ-019 SHALL map the holder's MODE to LED as: 00 OFF -> 00; 01 SOLID -> 11; 10 BLINK -> {~phase, phase}; 11 FLASH -> {phase, phase}.
REQ-020 In IDLE, LED SHALL be 00.
REQ-021 GNT and LED SHALL be registered and computed from next-state values, so they change on the same edge.
REQ-022 A MODE change SHALL reach LED one cycle later; MODE SHALL never affect arbitration.
REQ-023 Request-to-grant latency from IDLE SHALL be 1 cycle.

Reset
REQ-024 On RESET_N low, SHALL immediately (asynchronously) force state IDLE, GNT=00, LED=00, BUSY=0, tick/slot counters=0, phase=0 and last-served=1.
REQ-025 Reset asserted mid-slot SHALL abandon the grant; after release, arbitration SHALL restart per REQ-011/012.

Structure
REQ-026 SHALL place the mode codes (OFF, SOLID, BLINK, FLASH) and the FSM state encoding in shared package led_seq_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen (parameter TICK_DIV, inputs sync clear and enable, output tick pulse).
REQ-028 SHALL size the tick counter as clog2(TICK_DIV), minimum 1 bit, and the slot counter as clog2(SLOT_TICKS), minimum 1 bit.

Verification (TICK_DIV=4, SLOT_TICKS=2, slot = 8 cycles)
REQ-029 SHALL test single BLINK request: REQ=01, MODE0=10 -> GNT=01 one cycle later; LED=10 for 4 cycles, then 01 for 4 cycles, and repeats; GNT stays 01 across the slot restart.
REQ-030 SHALL test round-robin: REQ=11 from reset -> GNT=01 for 8 cycles, then 10 for 8, then 01; BUSY=1 throughout.
REQ-031 SHALL test holder drop: in GRANT0 at cycle 3 of the slot, REQ goes 11 -> 10 -> GNT=10 next edge, with MODE1=10 giving LED=10 (phase restarted).
REQ-032 SHALL test mode change: GRANT0 with MODE0 01 -> 00 mid-slot -> LED goes 11 -> 00 one cycle later; GNT stays 01.
REQ-033 SHALL test async reset: RESET_N pulsed low mid-slot between clock edges -> GNT=00, LED=00, BUSY=0 before the next edge; REQ=11 after release -> GNT=01.
